// File: rtl/punc_control.sv
// ============================================================================
// Module      : punc_control
// Description : PUnC LC3 control FSM; decodes ir into datapath selects/enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module punc_control #(
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [15:0] ir,
    input  logic       n,
    input  logic       z,
    input  logic       p,
    output logic       mem_w_en,
    output logic [1:0] mem_w_addr_sel,
    output logic       mem_w_data_sel,
    output logic [1:0] mem_r_addr_sel,
    output logic       rf_w_en,
    output logic       rf_r0_addr_sel,
    output logic       rf_r1_addr_sel,
    output logic [1:0] rf_w_data_sel,
    output logic       rf_w_addr_sel,
    output logic       ir_ld,
    output logic       pc_ld,
    output logic       pc_clr,
    output logic       pc_inc,
    output logic [1:0] pc_ld_data_sel,
    output logic [2:0] alu_sel,
    output logic       cond_ld,
    output logic       cond_ld_data_sel,
    output logic       ldi_reg_ld,
    output logic       halted
);

    localparam logic [3:0] c_OP_BR  = 4'b0000;
    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_ST  = 4'b0011;
    localparam logic [3:0] c_OP_JSR = 4'b0100;
    localparam logic [3:0] c_OP_AND = 4'b0101;
    localparam logic [3:0] c_OP_LDR = 4'b0110;
    localparam logic [3:0] c_OP_STR = 4'b0111;
    localparam logic [3:0] c_OP_NOT = 4'b1001;
    localparam logic [3:0] c_OP_LDI = 4'b1010;
    localparam logic [3:0] c_OP_STI = 4'b1011;
    localparam logic [3:0] c_OP_JMP = 4'b1100;
    localparam logic [3:0] c_OP_LEA = 4'b1110;

    localparam logic [2:0] c_ALU_ADD   = 3'd0;
    localparam logic [2:0] c_ALU_ADDI  = 3'd1;
    localparam logic [2:0] c_ALU_NOT   = 3'd2;
    localparam logic [2:0] c_ALU_AND   = 3'd3;
    localparam logic [2:0] c_ALU_ANDI  = 3'd4;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] w_opcode;
    logic       w_br_taken;
    logic       w_unused_ir;

    assign w_opcode    = ir[15:12];
    // nzp = 000 never matches, so that encoding is effectively a NOP.
    assign w_br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign w_unused_ir = ^{ir[8:6], ir[4:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (w_opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else if (w_opcode == c_OP_LDI) begin
                    state_d = S_EXEC2;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC2:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        mem_w_en         = 1'b0;
        mem_w_addr_sel   = 2'd0;
        mem_w_data_sel   = 1'b0;
        mem_r_addr_sel   = 2'd0;
        rf_w_en          = 1'b0;
        rf_r0_addr_sel   = 1'b0;
        rf_r1_addr_sel   = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_w_addr_sel    = 1'b0;
        ir_ld            = 1'b0;
        pc_ld            = 1'b0;
        pc_clr           = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;
        ldi_reg_ld       = 1'b0;
        halted           = 1'b0;

        case (state_q)
            S_INIT: pc_clr = 1'b1;
            S_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_EXEC: begin
                if (w_opcode != HALT_OPCODE) begin
                    case (w_opcode)
                        c_OP_ADD: begin
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                            alu_sel = ir[5] ? c_ALU_ADDI : c_ALU_ADD;
                        end
                        c_OP_AND: begin
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                            alu_sel = ir[5] ? c_ALU_ANDI : c_ALU_AND;
                        end
                        c_OP_NOT: begin
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                            alu_sel = c_ALU_NOT;
                        end
                        c_OP_BR:  pc_ld = w_br_taken;
                        c_OP_JMP: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = 2'd1;
                        end
                        // Link write and PC load share an edge, so JSRR R7 jumps to the old R7.
                        c_OP_JSR: begin
                            rf_w_en        = 1'b1;
                            rf_w_data_sel  = 2'd2;
                            rf_w_addr_sel  = 1'b1;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                        end
                        c_OP_LD, c_OP_LDR: begin
                            mem_r_addr_sel   = (w_opcode == c_OP_LD) ? 2'd1 : 2'd2;
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        c_OP_LEA: begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd3;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        c_OP_ST: begin
                            mem_w_en       = 1'b1;
                            rf_r0_addr_sel = 1'b1;
                        end
                        c_OP_STR: begin
                            mem_w_en       = 1'b1;
                            mem_w_addr_sel = 2'd1;
                            rf_r0_addr_sel = 1'b1;
                            rf_r1_addr_sel = 1'b1;
                        end
                        c_OP_STI: begin
                            mem_w_en       = 1'b1;
                            mem_r_addr_sel = 2'd1;
                            mem_w_addr_sel = 2'd2;
                            rf_r0_addr_sel = 1'b1;
                        end
                        c_OP_LDI: begin
                            mem_r_addr_sel = 2'd1;
                            ldi_reg_ld     = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC2: begin
                mem_r_addr_sel   = 2'd3;
                rf_w_en          = 1'b1;
                rf_w_data_sel    = 2'd1;
                cond_ld          = 1'b1;
                cond_ld_data_sel = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_punc_control.sv
// ============================================================================
// Module      : tb_punc_control
// Description : Directed self-checking bench for punc_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_punc_control;

    typedef struct packed {
        logic       halted;
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
        logic       ldi_reg_ld;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir  = 16'h0000;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;

    logic       mem_w_en, mem_w_data_sel, rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
    logic       rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc, cond_ld, cond_ld_data_sel;
    logic       ldi_reg_ld, halted;
    logic [1:0] mem_w_addr_sel, mem_r_addr_sel, rf_w_data_sel, pc_ld_data_sel;
    logic [2:0] alu_sel;

    ctl_t obs;
    ctl_t e;
    int   errors = 0;
    int   checks = 0;

    assign obs = {halted, mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel,
                  rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel,
                  ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel, cond_ld,
                  cond_ld_data_sel, ldi_reg_ld};

    punc_control #(.HALT_OPCODE(4'hF)) dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel),
        .mem_w_data_sel(mem_w_data_sel), .mem_r_addr_sel(mem_r_addr_sel),
        .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
        .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel),
        .rf_w_addr_sel(rf_w_addr_sel), .ir_ld(ir_ld), .pc_ld(pc_ld),
        .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld_data_sel(pc_ld_data_sel),
        .alu_sel(alu_sel), .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel),
        .ldi_reg_ld(ldi_reg_ld), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(negedge clk);
    endtask

    // From a FETCH-state sample point, present ir and advance into EXEC.
    task automatic goto_exec(input logic [15:0] v);
        ir = v;
        cyc();
        cyc();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        e = '0; e.pc_clr = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, e); end
        cyc();
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_hold_edge: got %h expected %h", obs, e); end
        rst = 1'b0;
        ir  = 16'h1261;
        checks++; if (obs !== e) begin errors++; $display("FAIL init_pc_clr: got %h expected %h", obs, e); end
        cyc();
        e = '0; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL fetch: got %h expected %h", obs, e); end
        cyc();
        e = '0;
        checks++; if (obs !== e) begin errors++; $display("FAIL decode: got %h expected %h", obs, e); end
        cyc();
        e = '0; e.rf_w_en = 1'b1; e.alu_sel = 3'd1; e.cond_ld = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL add_imm_exec: got %h expected %h", obs, e); end
        cyc();
        e = '0; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL add_next_fetch: got %h expected %h", obs, e); end
    endtask

    task automatic test_alu;
        logic [15:0] v;
        logic [2:0]  a;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin v = 16'h1042; a = 3'd0; end
                1: begin v = 16'h5042; a = 3'd3; end
                2: begin v = 16'h5262; a = 3'd4; end
                default: begin v = 16'h927F; a = 3'd2; end
            endcase
            goto_exec(v);
            e = '0; e.rf_w_en = 1'b1; e.alu_sel = a; e.cond_ld = 1'b1;
            checks++; if (obs !== e) begin errors++; $display("FAIL alu_%0d ir=%h: got %h expected %h", i, v, obs, e); end
            cyc();
        end
    endtask

    task automatic test_branch;
        logic [15:0] v;
        logic        take;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin v = 16'h0405; {n, z, p} = 3'b010; take = 1'b1; end
                1: begin v = 16'h0405; {n, z, p} = 3'b100; take = 1'b0; end
                2: begin v = 16'h0E00; {n, z, p} = 3'b001; take = 1'b1; end
                default: begin v = 16'h0000; {n, z, p} = 3'b111; take = 1'b0; end
            endcase
            goto_exec(v);
            e = '0; e.pc_ld = take;
            checks++; if (obs !== e) begin errors++; $display("FAIL br_%0d ir=%h: got %h expected %h", i, v, obs, e); end
            cyc();
            e = '0; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
            checks++; if (obs !== e) begin errors++; $display("FAIL br_%0d_fetch: got %h expected %h", i, obs, e); end
        end
        {n, z, p} = 3'b000;
    endtask

    task automatic test_ldi;
        goto_exec(16'hA402);
        e = '0; e.mem_r_addr_sel = 2'd1; e.ldi_reg_ld = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL ldi_exec: got %h expected %h", obs, e); end
        cyc();
        e = '0; e.mem_r_addr_sel = 2'd3; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd1;
        e.cond_ld = 1'b1; e.cond_ld_data_sel = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL ldi_exec2: got %h expected %h", obs, e); end
        cyc();
        e = '0; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL ldi_fetch: got %h expected %h", obs, e); end
    endtask

    task automatic test_jump;
        logic [15:0] v;
        for (int i = 0; i < 3; i++) begin
            e = '0; e.pc_ld = 1'b1;
            case (i)
                0: begin v = 16'h41C0; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd2;
                         e.rf_w_addr_sel = 1'b1; e.pc_ld_data_sel = 2'd1; end
                1: begin v = 16'h4805; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd2;
                         e.rf_w_addr_sel = 1'b1; e.pc_ld_data_sel = 2'd2; end
                default: begin v = 16'hC1C0; e.pc_ld_data_sel = 2'd1; end
            endcase
            goto_exec(v);
            checks++; if (obs !== e) begin errors++; $display("FAIL jump_%0d ir=%h: got %h expected %h", i, v, obs, e); end
            cyc();
        end
    endtask

    task automatic test_mem;
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            e = '0;
            case (i)
                0: begin v = 16'hB603; e.mem_w_en = 1'b1; e.mem_w_addr_sel = 2'd2;
                         e.mem_r_addr_sel = 2'd1; e.rf_r0_addr_sel = 1'b1; end
                1: begin v = 16'h3603; e.mem_w_en = 1'b1; e.rf_r0_addr_sel = 1'b1; end
                2: begin v = 16'h7642; e.mem_w_en = 1'b1; e.mem_w_addr_sel = 2'd1;
                         e.rf_r0_addr_sel = 1'b1; e.rf_r1_addr_sel = 1'b1; end
                3: begin v = 16'h2602; e.mem_r_addr_sel = 2'd1; e.rf_w_en = 1'b1;
                         e.rf_w_data_sel = 2'd1; e.cond_ld = 1'b1; e.cond_ld_data_sel = 1'b1; end
                4: begin v = 16'h6642; e.mem_r_addr_sel = 2'd2; e.rf_w_en = 1'b1;
                         e.rf_w_data_sel = 2'd1; e.cond_ld = 1'b1; e.cond_ld_data_sel = 1'b1; end
                5: begin v = 16'hE602; e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd3;
                         e.cond_ld = 1'b1; e.cond_ld_data_sel = 1'b1; end
                6: v = 16'h8000;
                default: v = 16'hD000;
            endcase
            goto_exec(v);
            checks++; if (obs !== e) begin errors++; $display("FAIL mem_%0d ir=%h: got %h expected %h", i, v, obs, e); end
            cyc();
            e = '0; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
            checks++; if (obs !== e) begin errors++; $display("FAIL mem_%0d_fetch: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_halt;
        int bad;
        goto_exec(16'hF025);
        e = '0;
        checks++; if (obs !== e) begin errors++; $display("FAIL halt_exec: got %h expected %h", obs, e); end
        bad = 0;
        e.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            ir = 16'h1261;
            checks++; if (obs !== e) begin errors++; bad++; if (bad < 4) $display("FAIL halt_hold_%0d: got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        goto_exec(16'h1261);
        e = '0; e.rf_w_en = 1'b1; e.alu_sel = 3'd1; e.cond_ld = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL mid_exec: got %h expected %h", obs, e); end
        rst = 1'b1;
        #1;
        e = '0; e.pc_clr = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL mid_rst_async: got %h expected %h", obs, e); end
        cyc();
        rst = 1'b0;
        cyc();
        e = '0; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
        checks++; if (obs !== e) begin errors++; $display("FAIL mid_rst_refetch: got %h expected %h", obs, e); end
    endtask

    initial begin
        cyc();
        test_reset();
        test_alu();
        test_branch();
        test_ldi();
        test_jump();
        test_mem();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
